wrr_queue_scheduler: RTL
========================

Name: wrr_queue_scheduler

Overview:
- Packet-granular weighted round-robin scheduler for the egress read controller.
- Selects one of ARB_NUM output queues and grants it for exactly one packet.
- Holds the grant until the read datapath reports end of packet, then debits that queue's per-round credit.
- Owns the per-queue weight/credit state, round-robin pointer and round refresh, so the read datapath sees a single grant/ack/done handshake.

Parameters:
- ARB_NUM, 8, number of queues/requesters (>=2).
- WEIGHT_W, 4, width of each weight/credit field, in packets per round.

Ports:
- iClk  in  1  clock
- iRst_n  in  1  reset; asynchronous, active-low
- iReq  in  ARB_NUM  queue i holds >=1 complete packet; level
- iWeight  in  ARB_NUM*WEIGHT_W  packed weights; queue i at bits [i*WEIGHT_W +: WEIGHT_W]
- iWeightLoad  in  1  single-cycle strobe; capture iWeight
- oGnt  out  ARB_NUM  one-hot granted queue; all-zero when no grant
- oGntValid  out  1  grant offered, waiting for iGntAck
- iGntAck  in  1  datapath accepted the grant and started reading
- iPktDone  in  1  single-cycle pulse; last word of granted packet read
- oBusy  out  1  high in GRANT and XFER
- oRoundEnd  out  1  one-cycle pulse on the credit-refresh cycle

Behaviour:
- Reset values:
  - oGnt=0, oGntValid=0, oBusy=0, oRoundEnd=0.
  - State IDLE, pointer=0.
  - initW[i] = credit[i] = all-ones (2^WEIGHT_W-1).
- Eligibility: eligible[i] = iReq[i] & (credit[i]!=0).
- FSM states: IDLE, GRANT, XFER. All outputs are registered.
- IDLE:
  - If eligible!=0: select the first eligible index at or after pointer, searching upward and wrapping past ARB_NUM-1 to 0. Next cycle: oGnt=onehot(sel), oGntValid=1, state GRANT.
  - Else if the request set (iReq & initW!=0) is non-empty: refresh cycle. credit[i]<=initW[i] for all i, oRoundEnd=1 next cycle, stay IDLE. Selection happens on the following cycle.
  - Else: stay IDLE, no pulse. This covers no requests, and requests only from weight-0 queues, so oRoundEnd never pulses repeatedly.
- GRANT:
  - oGnt and oGntValid are held.
  - If iGntAck: oGntValid=0 next cycle, oGnt held, state XFER.
  - If iReq[g] deasserts without iGntAck in the same cycle: oGnt=0, oGntValid=0, state IDLE. No credit debit, pointer unchanged.
  - iGntAck takes priority over a simultaneous iReq drop.
- XFER:
  - oGnt is held. iReq changes are ignored.
  - On iPktDone: credit[g] decrements, saturating at 0; pointer=(g+1) mod ARB_NUM; oGnt=0; state IDLE.
- iPktDone or iGntAck outside its owning state is ignored.
- Minimum spacing: iPktDone at cycle T gives IDLE at T+1 and the next oGntValid at T+2.
- iWeightLoad, any state:
  - initW[i]<=w[i] and credit[i]<=w[i] for all i.
  - The in-flight packet is not aborted. A later iPktDone debits the newly loaded credit, saturating.
  - If iWeightLoad and iPktDone coincide, the load wins for all queues, including g.
- Weight 0 means the queue is never served.
- Refresh and load never coincide. Refresh occurs only in IDLE with eligible==0, and iWeightLoad suppresses refresh that cycle.
- Reset mid-packet: all state returns to reset values immediately. The datapath is reset on the same iRst_n.
- Assertions:
  - oGnt is one-hot or zero.
  - oGntValid implies oGnt!=0.
  - oBusy==(state!=IDLE).

Test Plan:
- Reset, then ARB_NUM=8, weights all 1, iReq=8'hFF, immediate ack, done 3 cycles after ack -> grants q0..q7 in order. oRoundEnd pulses once after q7. Next round starts at q0.
- Weights q0=3, q1=1, others 0; iReq=8'h03 constant -> per round the grant sequence is q0,q1,q0,q0 (pointer rotation), then oRoundEnd. Over 4 rounds the packet counts are q0=12 and q1=4.
- Weights q2=2, q5=2; iReq only q5 until q5 credit=0, then q2 asserts -> q2 served twice with no refresh. oRoundEnd fires only when both credits are 0 and a request is pending.
- q3 in GRANT, iReq[3] drops with no ack -> oGnt returns to 0 next cycle. credit[3] is unchanged and the pointer stays at 3.
- iWeightLoad with q4=5 while q4 is in XFER with credit 1, then iPktDone -> credit[4]=4 and oGnt stays high until done. iWeightLoad coincident with iPktDone gives credit[4]=5.
- All weights 0 and iReq=8'hFF for 50 cycles -> no grant and no oRoundEnd. iRst_n asserted mid-XFER -> oGnt=0 and oBusy=0 immediately, credits all 15.

Source files
------------

// File: rtl/wrr_queue_scheduler.sv
// Packet-granular weighted round-robin scheduler: grants one queue per packet,
// debits per-round credit on packet completion and refreshes credit per round.
module wrr_queue_scheduler #(
   parameter int unsigned ARB_NUM  = 8,
   parameter int unsigned WEIGHT_W = 4
) (
   input  logic                        iClk,
   input  logic                        iRst_n,
   input  logic [ARB_NUM-1:0]          iReq,
   input  logic [ARB_NUM*WEIGHT_W-1:0] iWeight,
   input  logic                        iWeightLoad,
   output logic [ARB_NUM-1:0]          oGnt,
   output logic                        oGntValid,
   input  logic                        iGntAck,
   input  logic                        iPktDone,
   output logic                        oBusy,
   output logic                        oRoundEnd
);

   localparam int unsigned IDX_W = (ARB_NUM > 1) ? $clog2(ARB_NUM) : 1;

   typedef enum logic [1:0] {IDLE, GRANT, XFER} state_t;

   state_t                             state_q, state_d;
   logic [IDX_W-1:0]                   ptr_q, ptr_d;
   logic [IDX_W-1:0]                   gidx_q, gidx_d;
   logic [ARB_NUM-1:0]                 gnt_q, gnt_d;
   logic                               gnt_valid_q, gnt_valid_d;
   logic                               round_end_q, round_end_d;
   logic                               busy_q;
   logic [ARB_NUM-1:0][WEIGHT_W-1:0]   initw_q, initw_d;
   logic [ARB_NUM-1:0][WEIGHT_W-1:0]   credit_q, credit_d;

   logic [ARB_NUM-1:0]                 eligible;
   logic [ARB_NUM-1:0]                 reqset;
   logic                               sel_found;
   logic [IDX_W-1:0]                   sel_idx;

   // Rotating search: first eligible queue at or after the pointer, wrapping.
   always_comb begin
      int unsigned idx;
      idx       = 0;
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int unsigned i = 0; i < ARB_NUM; i++) begin
         eligible[i] = iReq[i] & (credit_q[i] != '0);
         reqset[i]   = iReq[i] & (initw_q[i] != '0);
      end
      for (int unsigned k = 0; k < ARB_NUM; k++) begin
         idx = (32'(ptr_q) + k) % ARB_NUM;
         if (!sel_found && eligible[idx[IDX_W-1:0]]) begin
            sel_found = 1'b1;
            sel_idx   = idx[IDX_W-1:0];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      gidx_d      = gidx_q;
      gnt_d       = gnt_q;
      gnt_valid_d = gnt_valid_q;
      round_end_d = 1'b0;
      initw_d     = initw_q;
      credit_d    = credit_q;
      case (state_q)
         IDLE: begin
            if (sel_found) begin
               state_d         = GRANT;
               gidx_d          = sel_idx;
               gnt_d           = '0;
               gnt_d[sel_idx]  = 1'b1;
               gnt_valid_d     = 1'b1;
            end else if ((reqset != '0) && !iWeightLoad) begin
               credit_d    = initw_q;
               round_end_d = 1'b1;
            end
         end
         GRANT: begin
            if (iGntAck) begin
               gnt_valid_d = 1'b0;
               state_d     = XFER;
            end else if (!iReq[gidx_q]) begin
               gnt_d       = '0;
               gnt_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         XFER: begin
            if (iPktDone) begin
               if (credit_q[gidx_q] != '0)
                  credit_d[gidx_q] = credit_q[gidx_q] - 1'b1;
               ptr_d   = (gidx_q == IDX_W'(ARB_NUM - 1)) ? '0 : IDX_W'(gidx_q + 1'b1);
               gnt_d   = '0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d     = IDLE;
            gnt_d       = '0;
            gnt_valid_d = 1'b0;
         end
      endcase
      // A weight load overrides any debit or refresh computed above.
      if (iWeightLoad) begin
         initw_d  = iWeight;
         credit_d = iWeight;
      end
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         gidx_q      <= '0;
         gnt_q       <= '0;
         gnt_valid_q <= 1'b0;
         round_end_q <= 1'b0;
         busy_q      <= 1'b0;
         initw_q     <= '1;
         credit_q    <= '1;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         gidx_q      <= gidx_d;
         gnt_q       <= gnt_d;
         gnt_valid_q <= gnt_valid_d;
         round_end_q <= round_end_d;
         busy_q      <= (state_d != IDLE);
         initw_q     <= initw_d;
         credit_q    <= credit_d;
      end
   end

   always_ff @(posedge iClk) begin
      if (iRst_n) begin
         assert ($onehot0(gnt_q)) else $error("grant not one-hot");
         assert (!gnt_valid_q || (gnt_q != '0)) else $error("valid without grant");
         assert (busy_q == (state_q != IDLE)) else $error("busy mismatch");
      end
   end

   assign oGnt      = gnt_q;
   assign oGntValid = gnt_valid_q;
   assign oBusy     = busy_q;
   assign oRoundEnd = round_end_q;

endmodule
